// File: rtl/avalon_s_arbiter_if.sv
// Host-side and device-side Avalon signals of the many-to-one arbiter.
// The slave view belongs to the arbiter; the master view drives the hosts and models the device.
interface avalon_s_arbiter_if #(
  parameter int unsigned NH = 2,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  localparam int unsigned BW = DW / 8;

  logic [NH-1:0]          hosts_avn_read;
  logic [NH-1:0]          hosts_avn_write;
  logic [NH-1:0][AW-1:0]  hosts_avn_address;
  logic [NH-1:0][BW-1:0]  hosts_avn_byte_enable;
  logic [NH-1:0][DW-1:0]  hosts_avn_writedata;
  logic [NH-1:0][DW-1:0]  hosts_avn_readdata;
  logic [NH-1:0]          hosts_avn_waitrequest;

  logic                   device_avn_read;
  logic                   device_avn_write;
  logic [AW-1:0]          device_avn_address;
  logic [BW-1:0]          device_avn_byte_enable;
  logic [DW-1:0]          device_avn_writedata;
  logic [DW-1:0]          device_avn_readdata;
  logic                   device_avn_waitrequest;

  modport slave (
    input  hosts_avn_read, hosts_avn_write, hosts_avn_address,
           hosts_avn_byte_enable, hosts_avn_writedata,
    output hosts_avn_readdata, hosts_avn_waitrequest,
    output device_avn_read, device_avn_write, device_avn_address,
           device_avn_byte_enable, device_avn_writedata,
    input  device_avn_readdata, device_avn_waitrequest
  );

  modport master (
    output hosts_avn_read, hosts_avn_write, hosts_avn_address,
           hosts_avn_byte_enable, hosts_avn_writedata,
    input  hosts_avn_readdata, hosts_avn_waitrequest,
    input  device_avn_read, device_avn_write, device_avn_address,
           device_avn_byte_enable, device_avn_writedata,
    output device_avn_readdata, device_avn_waitrequest
  );
endinterface

// File: rtl/avalon_s_arbiter.sv
// Round-robin arbiter sharing one Avalon device among NH hosts, with grant lock
// during device stalls and read data steered back to the accepting host.
module avalon_s_arbiter #(
  parameter int unsigned NH = 2,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  avalon_s_arbiter_if.slave bus
);
  localparam int unsigned IW = (NH > 1) ? $clog2(NH) : 1;

  logic [NH-1:0] req;
  logic [IW-1:0] last_grant;
  logic          lock_valid;
  logic [IW-1:0] lock_idx;
  logic          rd_valid;
  logic [IW-1:0] rd_owner;

  logic [IW-1:0] rr_pick;
  logic [IW-1:0] cand;
  int unsigned   idx;
  logic [IW-1:0] grant;
  logic          grant_valid;
  logic          accept;
  logic          rd_accept;

  assign req = bus.hosts_avn_read | bus.hosts_avn_write;

  // Scan from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    rr_pick = last_grant;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = NH; k > 0; k--) begin
      idx  = (32'(last_grant) + k) % NH;
      cand = IW'(idx);
      if (req[cand]) rr_pick = cand;
    end
  end

  assign grant       = lock_valid ? lock_idx : rr_pick;
  assign grant_valid = req[grant];

  // Device mux, host waitrequest fan-out and read-data steering.
  always_comb begin
    bus.device_avn_read        = grant_valid & bus.hosts_avn_read[grant];
    bus.device_avn_write       = grant_valid & bus.hosts_avn_write[grant];
    bus.device_avn_address     = bus.hosts_avn_address[grant];
    bus.device_avn_byte_enable = bus.hosts_avn_byte_enable[grant];
    bus.device_avn_writedata   = bus.hosts_avn_writedata[grant];

    bus.hosts_avn_waitrequest = '1;
    if (grant_valid) bus.hosts_avn_waitrequest[grant] = bus.device_avn_waitrequest;

    bus.hosts_avn_readdata = '0;
    for (int unsigned i = 0; i < NH; i++) begin
      if (rd_valid && (rd_owner == IW'(i))) bus.hosts_avn_readdata[i] = bus.device_avn_readdata;
    end
  end

  assign accept    = (bus.device_avn_read | bus.device_avn_write) & ~bus.device_avn_waitrequest;
  assign rd_accept = bus.device_avn_read & ~bus.device_avn_waitrequest;

  // Lock and round-robin pointer; a stalled host that drops its request releases the lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IW'(NH - 1);
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      rd_valid   <= 1'b0;
      rd_owner   <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_owner <= grant;

      if (accept) begin
        lock_valid <= 1'b0;
        last_grant <= grant;
      end else if (grant_valid) begin
        lock_valid <= 1'b1;
        lock_idx   <= grant;
      end else begin
        lock_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_avalon_s_arbiter.sv
// Directed bench for avalon_s_arbiter with NH=4: host drivers, a device model and
// a scoreboard monitor that checks every accepted transfer and every read return.
module tb_avalon_s_arbiter;
  localparam int unsigned NH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  avalon_s_arbiter_if #(.NH(NH), .DW(DW), .AW(AW)) hif ();

  avalon_s_arbiter #(.NH(NH), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int unsigned   host;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  cmd_t        cmd_q [NH][$];
  exp_t        exp_q [$];
  logic [NH-1:0] busy;
  int          total = 0;
  int          bad   = 0;

  // Device: read data one cycle after a read accept, garbage otherwise.
  always @(posedge clk) begin
    if (hif.device_avn_read && !hif.device_avn_waitrequest) begin
      if (hif.device_avn_address == 32'h0000_0100)
        hif.device_avn_readdata <= 32'hDEAD_BEEF;
      else
        hif.device_avn_readdata <= {16'hC0DE, hif.device_avn_address[15:0]};
    end else begin
      hif.device_avn_readdata <= 32'hBAD0_0000;
    end
  end

  // Host drivers: hold each command until its waitrequest is seen low.
  initial begin
    logic [NH-1:0] acc;
    cmd_t c;
    hif.hosts_avn_read        = '0;
    hif.hosts_avn_write       = '0;
    hif.hosts_avn_address     = '0;
    hif.hosts_avn_byte_enable = '0;
    hif.hosts_avn_writedata   = '0;
    busy = '0;
    forever begin
      @(negedge clk);
      acc = busy & ~hif.hosts_avn_waitrequest & {NH{rst}};
      @(posedge clk);
      #2;
      for (int h = 0; h < int'(NH); h++) begin
        if (acc[h]) begin
          busy[h] = 1'b0;
          hif.hosts_avn_read[h]  = 1'b0;
          hif.hosts_avn_write[h] = 1'b0;
        end
        if (!busy[h] && cmd_q[h].size() != 0) begin
          c = cmd_q[h].pop_front();
          hif.hosts_avn_read[h]        = c.rd;
          hif.hosts_avn_write[h]       = ~c.rd;
          hif.hosts_avn_address[h]     = c.addr;
          hif.hosts_avn_writedata[h]   = c.wdata;
          hif.hosts_avn_byte_enable[h] = BW'(1) << h;
          busy[h] = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: device accepts and read returns, sampled on the falling edge.
  initial begin
    logic pend;
    exp_t cur_rd;
    exp_t e;
    logic [NH-1:0][DW-1:0] exp_rd;
    logic [NH-1:0] exp_wr;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      exp_rd = '0;
      if (rst && pend) exp_rd[cur_rd.host] = cur_rd.rdata;
      total++;
      if (hif.hosts_avn_readdata !== exp_rd) begin
        bad++;
        $display("FAIL readdata t=%0t actual=%h required=%h", $time, hif.hosts_avn_readdata, exp_rd);
      end
      pend = 1'b0;
      if (rst && (hif.device_avn_read || hif.device_avn_write) && !hif.device_avn_waitrequest) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL xfer t=%0t unexpected accept addr=%h", $time, hif.device_avn_address);
        end else begin
          e = exp_q.pop_front();
          exp_wr = ~(NH'(1) << e.host);
          if ({hif.hosts_avn_waitrequest, hif.device_avn_read, hif.device_avn_write,
               hif.device_avn_address, hif.device_avn_writedata, hif.device_avn_byte_enable} !==
              {exp_wr, e.rd, ~e.rd, e.addr, e.wdata, BW'(1) << e.host}) begin
            bad++;
            $display("FAIL xfer t=%0t actual wr=%b rd=%b we=%b a=%h d=%h be=%h required host=%0d wr=%b rd=%b a=%h d=%h",
                     $time, hif.hosts_avn_waitrequest, hif.device_avn_read, hif.device_avn_write,
                     hif.device_avn_address, hif.device_avn_writedata, hif.device_avn_byte_enable,
                     e.host, exp_wr, e.rd, e.addr, e.wdata);
          end
          if (e.rd) begin
            pend   = 1'b1;
            cur_rd = e;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned h, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.rd = rd;
    c.addr = a;
    c.wdata = d;
    cmd_q[h].push_back(c);
  endtask

  task automatic expect_x(input int unsigned h, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] r);
    exp_t e;
    e.host = h;
    e.rd = rd;
    e.addr = a;
    e.wdata = d;
    e.rdata = r;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || (busy != '0);
    for (int h = 0; h < int'(NH); h++) if (cmd_q[h].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({name, "_drained"}, 64'(pending()), 64'(0));
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hif.device_avn_waitrequest = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdwr", 64'({hif.device_avn_read, hif.device_avn_write}), 64'(0));
    check("rst_wait", 64'(hif.hosts_avn_waitrequest), 64'(4'hF));
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Simultaneous writes: host0 first, host1 next cycle
    issue(0, 1'b0, 32'h10, 32'h1111_0000);
    issue(1, 1'b0, 32'h14, 32'h2222_0000);
    expect_x(0, 1'b0, 32'h10, 32'h1111_0000, '0);
    expect_x(1, 1'b0, 32'h14, 32'h2222_0000, '0);
    drain("t1", 20);

    // Host1 read stalled 3 cycles, host0 arrives mid-stall
    hif.device_avn_waitrequest = 1'b1;
    issue(1, 1'b1, 32'h100, '0);
    expect_x(1, 1'b1, 32'h100, '0, 32'hDEAD_BEEF);
    expect_x(0, 1'b1, 32'h20, '0, 32'hC0DE_0020);
    @(negedge clk);
    check("stall_addr0", 64'(hif.device_avn_address), 64'(32'h100));
    tick();
    issue(0, 1'b1, 32'h20, '0);
    @(negedge clk);
    check("stall_addr1", 64'(hif.device_avn_address), 64'(32'h100));
    check("stall_wait1", 64'(hif.hosts_avn_waitrequest), 64'(4'hF));
    tick();
    @(negedge clk);
    check("stall_addr2", 64'(hif.device_avn_address), 64'(32'h100));
    tick();
    hif.device_avn_waitrequest = 1'b0;
    @(negedge clk);
    check("stall_addr3", 64'(hif.device_avn_address), 64'(32'h100));
    drain("t2", 20);

    // All four hosts reading continuously: round-robin from host1
    for (int r = 0; r < 2; r++) begin
      for (int h = 0; h < int'(NH); h++) begin
        issue(h, 1'b1, 32'h1000 + 32'(r) * 32'h100 + 32'(h) * 32'h10, '0);
      end
    end
    expect_x(1, 1'b1, 32'h1010, '0, 32'hC0DE_1010);
    expect_x(2, 1'b1, 32'h1020, '0, 32'hC0DE_1020);
    expect_x(3, 1'b1, 32'h1030, '0, 32'hC0DE_1030);
    expect_x(0, 1'b1, 32'h1000, '0, 32'hC0DE_1000);
    expect_x(1, 1'b1, 32'h1110, '0, 32'hC0DE_1110);
    expect_x(2, 1'b1, 32'h1120, '0, 32'hC0DE_1120);
    expect_x(3, 1'b1, 32'h1130, '0, 32'hC0DE_1130);
    expect_x(0, 1'b1, 32'h1100, '0, 32'hC0DE_1100);
    drain("t3", 40);

    // Alternating host0/host2 back-to-back reads
    issue(0, 1'b1, 32'h2000, '0);
    issue(0, 1'b1, 32'h2008, '0);
    issue(2, 1'b1, 32'h2200, '0);
    issue(2, 1'b1, 32'h2208, '0);
    expect_x(2, 1'b1, 32'h2200, '0, 32'hC0DE_2200);
    expect_x(0, 1'b1, 32'h2000, '0, 32'hC0DE_2000);
    expect_x(2, 1'b1, 32'h2208, '0, 32'hC0DE_2208);
    expect_x(0, 1'b1, 32'h2008, '0, 32'hC0DE_2008);
    drain("t4", 30);

    // Reset while host2 is locked in a stall
    hif.device_avn_waitrequest = 1'b1;
    issue(2, 1'b0, 32'h3000, 32'h3333_3333);
    @(negedge clk);
    check("lock_addr0", 64'(hif.device_avn_address), 64'(32'h3000));
    repeat (2) tick();
    issue(0, 1'b0, 32'h3004, 32'h4444_4444);
    @(negedge clk);
    check("lock_addr1", 64'(hif.device_avn_address), 64'(32'h3000));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant", 64'(hif.device_avn_address), 64'(32'h3004));
    tick();
    rst = 1'b1;
    expect_x(0, 1'b0, 32'h3004, 32'h4444_4444, '0);
    expect_x(2, 1'b0, 32'h3000, 32'h3333_3333, '0);
    hif.device_avn_waitrequest = 1'b0;
    drain("t5", 20);

    // Idle, then confirm the pointer still sits on host2
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_rdwr", 64'({hif.device_avn_read, hif.device_avn_write}), 64'(0));
      check("idle_wait", 64'(hif.hosts_avn_waitrequest), 64'(4'hF));
    end
    tick();
    issue(0, 1'b0, 32'h4000, 32'h0000_0055);
    issue(3, 1'b0, 32'h4030, 32'h0000_0066);
    expect_x(3, 1'b0, 32'h4030, 32'h0000_0066, '0);
    expect_x(0, 1'b0, 32'h4000, 32'h0000_0055, '0);
    drain("t6", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
